// File: rtl/spi_slave_module_pkg.sv
// Shared constants for the SPI mode-0 slave and its controller.
// Done-strobe indices, byte width and command opcodes.
package spi_slave_module_pkg;

  localparam int SPI_DONE_RX   = 0;
  localparam int SPI_DONE_TX   = 1;
  localparam int SPI_BYTE_BITS = 8;

  localparam logic [7:0] CMD_ID_QUERY = 8'h06;
  localparam logic [7:0] CMD_LED      = 8'hA1;
  localparam logic [7:0] CMD_COXA_PWM = 8'hA3;
  localparam logic [7:0] CMD_ID_REPLY = 8'hD4;

  function automatic logic [7:0] shift_in(
    input logic [7:0] v,
    input logic       b
  );
    return {v[6:0], b};
  endfunction

endpackage

// File: rtl/spi_slave_module_sync_edge.sv
// N-stage synchroniser for one asynchronous SPI pin.
// Edge pulses come from the last two stages so they align with q.
module spi_sync_edge_module #(
  parameter int   STAGES  = 3,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= {STAGES{RST_VAL}};
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q    = sr[STAGES-1];
  assign rise = sr[STAGES-2] & ~sr[STAGES-1];
  assign fall = ~sr[STAGES-2] & sr[STAGES-1];

endmodule

// File: rtl/spi_slave_module.sv
// SPI mode-0 slave byte engine (MSB first) with rx/tx done strobes.
// Define SPI_MISO_HIZ_EN to float miso while chip select is high.
module spi_slave_module
  import spi_slave_module_pkg::*;
#(
  parameter int SYNC_STAGES = 3,
  parameter int BYTE_W      = SPI_BYTE_BITS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       ncs,
  output logic       miso,
  input  logic       iCall,
  input  logic [7:0] iData,
  output logic [1:0] oDone,
  output logic [7:0] oData
);

  localparam int CW = $clog2(BYTE_W);
  localparam logic [CW-1:0] LAST = CW'(BYTE_W - 1);

  logic sclk_s;
  logic sclk_rise;
  logic sclk_fall;
  logic mosi_s;
  logic mosi_rise;
  logic mosi_fall;
  logic ncs_s;
  logic ncs_rise;
  logic ncs_fall;
  logic unused_edges;

  spi_sync_edge_module #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b0)
  ) u_sclk (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sclk),
    .q    (sclk_s),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge_module #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b0)
  ) u_mosi (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (mosi),
    .q    (mosi_s),
    .rise (mosi_rise),
    .fall (mosi_fall)
  );

  // Chip select resets deselected so no bit is taken before it settles.
  spi_sync_edge_module #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b1)
  ) u_ncs (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (ncs),
    .q    (ncs_s),
    .rise (ncs_rise),
    .fall (ncs_fall)
  );

  assign unused_edges = ^{sclk_s, mosi_rise, mosi_fall,
                          ncs_rise, ncs_fall};

  logic [CW-1:0]     bit_cnt;
  logic [BYTE_W-1:0] rx_shift;
  logic [BYTE_W-1:0] tx_shift;
  logic              tx_busy;
  logic              tx_armed;
  logic              done_rx;
  logic              done_tx;
  logic [BYTE_W-1:0] rx_next;
  logic              load;
  logic              miso_drv;

  always_comb begin
    rx_next = shift_in(rx_shift, mosi_s);
    load    = iCall & tx_armed & ~tx_busy & ~ncs_s
            & (bit_cnt == '0) & ~sclk_rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      tx_busy  <= 1'b0;
      tx_armed <= 1'b1;
      done_rx  <= 1'b0;
      done_tx  <= 1'b0;
      oData    <= '0;
    end else begin
      done_rx <= 1'b0;
      done_tx <= 1'b0;
      if (done_rx && tx_busy) begin
        done_tx <= 1'b1;
        tx_busy <= 1'b0;
      end
      // Re-arm only once the controller has dropped its call.
      if (!iCall) begin
        tx_armed <= 1'b1;
      end
      if (ncs_s) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
        tx_busy  <= 1'b0;
      end else begin
        if (sclk_rise) begin
          rx_shift <= rx_next;
          if (bit_cnt == LAST) begin
            bit_cnt <= '0;
            oData   <= rx_next;
            done_rx <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        if (sclk_fall && tx_busy && bit_cnt != '0) begin
          tx_shift <= {tx_shift[BYTE_W-2:0], 1'b0};
        end
        if (load) begin
          tx_shift <= iData;
          tx_busy  <= 1'b1;
          tx_armed <= 1'b0;
        end
      end
    end
  end

  assign oDone[SPI_DONE_RX] = done_rx;
  assign oDone[SPI_DONE_TX] = done_tx;
  assign miso_drv = tx_busy & tx_shift[BYTE_W-1];

`ifdef SPI_MISO_HIZ_EN
  assign miso = ncs_s ? 1'bz : miso_drv;
`else
  assign miso = ncs_s ? 1'b0 : miso_drv;
`endif

endmodule
